// File: rtl/siren_sweep_sequencer.sv
// Siren sweep sequencer: steps a 7-bit ramp index through the wail, yelp and hi-lo patterns and
// publishes the matching half-period reload value for the downstream square-wave divider.
module siren_sweep_sequencer #(
   parameter int unsigned STEP_WAIL = 16384,
   parameter int unsigned STEP_YELP = 2048,
   parameter int unsigned HILO_HOLD = 4194304,
   parameter logic [6:0]  HILO_A    = 7'd96,
   parameter logic [6:0]  HILO_B    = 7'd32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  mode,
   output logic [14:0] divider,
   output logic        div_load,
   output logic        tone_en
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RISE,
      S_FALL,
      S_HOLD_A,
      S_HOLD_B
   } state_t;

   localparam logic [23:0] LIM_WAIL = 24'(STEP_WAIL - 1);
   localparam logic [23:0] LIM_YELP = 24'(STEP_YELP - 1);
   localparam logic [23:0] LIM_HILO = 24'(HILO_HOLD - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [6:0]  r_ramp;
   logic [6:0]  w_ramp_nxt;
   logic [23:0] r_presc;
   logic [23:0] w_presc_nxt;
   logic [23:0] w_limit;
   logic [1:0]  r_mode_q;
   logic        w_change;
   logic        w_tick;
   logic [14:0] w_div_nxt;

   always_comb begin
      w_limit     = LIM_WAIL;
      w_state_nxt = r_state;
      w_ramp_nxt  = r_ramp;
      w_presc_nxt = r_presc + 24'd1;
      case (r_mode_q)
         2'd2:    w_limit = LIM_YELP;
         2'd3:    w_limit = LIM_HILO;
         default: w_limit = LIM_WAIL;
      endcase
      w_change = (mode != r_mode_q);
      w_tick   = (r_state != S_IDLE) && (r_presc == w_limit);

      // A mode change re-enters the new pattern and overrides any coincident tick.
      if (w_change) begin
         w_presc_nxt = 24'd0;
         case (mode)
            2'd0: begin
               w_state_nxt = S_IDLE;
               w_ramp_nxt  = 7'd0;
            end
            2'd3: begin
               w_state_nxt = S_HOLD_A;
               w_ramp_nxt  = HILO_A;
            end
            default: begin
               w_state_nxt = S_RISE;
               w_ramp_nxt  = 7'd0;
            end
         endcase
      end else if (r_state == S_IDLE) begin
         w_presc_nxt = 24'd0;
      end else if (w_tick) begin
         w_presc_nxt = 24'd0;
         case (r_state)
            S_RISE: begin
               if (r_ramp == 7'd127) begin
                  w_state_nxt = S_FALL;
                  w_ramp_nxt  = 7'd126;
               end else begin
                  w_ramp_nxt = r_ramp + 7'd1;
               end
            end
            S_FALL: begin
               if (r_ramp == 7'd0) begin
                  w_state_nxt = S_RISE;
                  w_ramp_nxt  = 7'd1;
               end else begin
                  w_ramp_nxt = r_ramp - 7'd1;
               end
            end
            S_HOLD_A: begin
               w_state_nxt = S_HOLD_B;
               w_ramp_nxt  = HILO_B;
            end
            S_HOLD_B: begin
               w_state_nxt = S_HOLD_A;
               w_ramp_nxt  = HILO_A;
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_ramp_nxt  = 7'd0;
            end
         endcase
      end
      w_div_nxt = {2'b01, w_ramp_nxt, 6'b000000};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_ramp   <= 7'd0;
         r_presc  <= 24'd0;
         r_mode_q <= 2'd0;
         divider  <= 15'h2000;
         div_load <= 1'b0;
         tone_en  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_ramp   <= w_ramp_nxt;
         r_presc  <= w_presc_nxt;
         r_mode_q <= mode;
         divider  <= w_div_nxt;
         div_load <= (w_div_nxt != divider);
         // Registered alongside mode_q so tone_en always mirrors (mode_q != 0).
         tone_en  <= (mode != 2'd0);
      end
   end

endmodule

// File: tb/tb_siren_sweep_sequencer.sv
// Directed bench for siren_sweep_sequencer with short step/hold parameters and a
// scoreboard of expected (cycle, divider) reload events.
module tb_siren_sweep_sequencer;

   logic        clk;
   logic        rst;
   logic [1:0]  mode;
   logic [14:0] divider;
   logic        div_load;
   logic        tone_en;
   logic [1:0]  mode2;
   logic [14:0] divider2;
   logic        div_load2;
   logic        tone_en2;

   int checks;
   int errors;
   int cyc;
   int pulses2;

   typedef struct {
      int          cyc;
      logic [14:0] div;
      string       tag;
   } exp_t;
   exp_t sb[$];

   siren_sweep_sequencer #(
      .STEP_WAIL(4), .STEP_YELP(2), .HILO_HOLD(8), .HILO_A(7'd96), .HILO_B(7'd32)
   ) dut (
      .clk(clk), .rst(rst), .mode(mode),
      .divider(divider), .div_load(div_load), .tone_en(tone_en)
   );

   siren_sweep_sequencer #(
      .STEP_WAIL(4), .STEP_YELP(2), .HILO_HOLD(8), .HILO_A(7'd40), .HILO_B(7'd40)
   ) dut_eq (
      .clk(clk), .rst(rst), .mode(mode2),
      .divider(divider2), .div_load(div_load2), .tone_en(tone_en2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [14:0] ramp_div(input int r);
      return 15'h2000 + 15'(r * 64);
   endfunction

   task automatic push(input int c, input logic [14:0] d, input string tag);
      exp_t e;
      e.cyc = c;
      e.div = d;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic wait_cyc(input int target);
      int guard;
      guard = 0;
      while (cyc < target && guard < 50000) begin
         @(negedge clk);
         guard++;
      end
      chk("wait_cyc_reached", 32'(cyc >= target), 32'd1);
   endtask

   initial begin
      int c0;
      int c1;
      int c2;
      int c3;
      int p0;
      cyc     = 0;
      checks  = 0;
      errors  = 0;
      pulses2 = 0;
      rst     = 1'b1;
      mode    = 2'd0;
      mode2   = 2'd0;

      fork
         forever begin
            exp_t e;
            @(negedge clk);
            if (div_load2 === 1'b1) pulses2++;
            if (!rst && div_load === 1'b1) begin
               chk("div_load_expected", 32'(sb.size() != 0), 32'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  chk({e.tag, "_divider"}, 32'(divider), 32'(e.div));
                  chk({e.tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
               end
            end
         end
      join_none

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_divider", 32'(divider), 32'h2000);
      chk("reset_div_load", 32'(div_load), 32'd0);
      chk("reset_tone_en", 32'(tone_en), 32'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("idle_divider", 32'(divider), 32'h2000);

      // Wail: full triangle plus a few extra steps up to ramp 10
      mode = 2'd1;
      c0 = cyc + 1;
      for (int k = 1; k <= 264; k++) begin
         int r;
         r = (k <= 127) ? k : ((k <= 254) ? 254 - k : k - 254);
         push(c0 + 4 * k, ramp_div(r), "wail_step");
      end
      wait_cyc(c0);
      chk("wail_entry_divider", 32'(divider), 32'h2000);
      chk("wail_entry_no_load", 32'(div_load), 32'd0);
      chk("wail_tone_en", 32'(tone_en), 32'd1);
      wait_cyc(c0 + 4 * 127);
      chk("wail_top", 32'(divider), 32'h3FC0);
      wait_cyc(c0 + 4 * 128);
      chk("wail_fall", 32'(divider), 32'h3F80);
      wait_cyc(c0 + 4 * 254);
      chk("wail_bottom", 32'(divider), 32'h2000);
      wait_cyc(c0 + 4 * 264 + 1);
      chk("wail_ramp10", 32'(divider), 32'h2280);
      chk("wail_sb_drained", 32'(sb.size()), 32'd0);

      // Sub-cycle asynchronous reset mid-RISE
      #2 rst = 1'b1;
      #1;
      chk("async_rst_divider", 32'(divider), 32'h2000);
      chk("async_rst_tone_en", 32'(tone_en), 32'd0);
      chk("async_rst_div_load", 32'(div_load), 32'd0);
      mode = 2'd0;
      #1 rst = 1'b0;
      repeat (50) @(negedge clk);
      chk("post_rst_divider", 32'(divider), 32'h2000);
      chk("post_rst_tone_en", 32'(tone_en), 32'd0);

      // Yelp to ramp 50, then switch to wail
      mode = 2'd2;
      c0 = cyc + 1;
      for (int k = 1; k <= 50; k++) push(c0 + 2 * k, ramp_div(k), "yelp_step");
      wait_cyc(c0 + 100);
      chk("yelp_ramp50", 32'(divider), 32'(ramp_div(50)));
      mode = 2'd1;
      c1 = cyc + 1;
      push(c1, 15'h2000, "yelp_to_wail");
      push(c1 + 4, ramp_div(1), "wail_restart1");
      push(c1 + 8, ramp_div(2), "wail_restart2");
      wait_cyc(c1 + 8);

      // Yelp with mode=0 landing on a tick cycle
      mode = 2'd2;
      c2 = cyc + 1;
      push(c2, 15'h2000, "yelp_entry");
      for (int k = 1; k <= 3; k++) push(c2 + 2 * k, ramp_div(k), "yelp_step2");
      wait_cyc(c2 + 7);
      mode = 2'd0;
      push(c2 + 8, 15'h2000, "collision_idle");
      wait_cyc(c2 + 8);
      chk("collision_divider", 32'(divider), 32'h2000);
      chk("collision_tone_en", 32'(tone_en), 32'd0);
      wait_cyc(c2 + 30);
      chk("collision_sb_drained", 32'(sb.size()), 32'd0);

      // Hi-lo alternation; second instance has equal tones
      p0 = pulses2;
      mode  = 2'd3;
      mode2 = 2'd3;
      c3 = cyc + 1;
      push(c3, 15'h3800, "hilo_a0");
      push(c3 + 8, 15'h2800, "hilo_b0");
      push(c3 + 16, 15'h3800, "hilo_a1");
      push(c3 + 24, 15'h2800, "hilo_b1");
      wait_cyc(c3);
      chk("hilo_tone_en", 32'(tone_en), 32'd1);
      wait_cyc(c3 + 4);
      chk("hilo_hold_a", 32'(divider), 32'h3800);
      wait_cyc(c3 + 26);
      chk("hilo_sb_drained", 32'(sb.size()), 32'd0);
      chk("hilo_eq_divider", 32'(divider2), 32'h2A00);
      chk("hilo_eq_pulses", 32'(pulses2 - p0), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
